// File: rtl/hazard_ctrl_pkg.sv
// Shared widths and FSM state encoding for the pipeline hazard/stall controller.
package defines;
   localparam int N        = 32;
   localparam int REG_AW   = 5;
   localparam int MC_CNT_W = 4;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      MC   = 2'd1,
      HALT = 2'd2,
      STEP = 2'd3
   } hz_state_t;
endpackage

// File: rtl/hazard_ctrl_loaduse_detect.sv
// Combinational load-use compare: a load in EX whose destination feeds a
// source register actually read by the instruction in ID.
module loaduse_detect (
   input  logic [defines::REG_AW-1:0] id_rs1,
   input  logic [defines::REG_AW-1:0] id_rs2,
   input  logic                       id_use_rs1,
   input  logic                       id_use_rs2,
   input  logic [defines::REG_AW-1:0] ex_rd,
   input  logic                       ex_mem_read,
   output logic                       hazard
);
   import defines::*;

   logic rs1Hit;
   logic rs2Hit;

   assign rs1Hit = id_use_rs1 && (id_rs1 == ex_rd);
   assign rs2Hit = id_use_rs2 && (id_rs2 == ex_rd);

   // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
   assign hazard = ex_mem_read && (ex_rd != '0) && (rs1Hit || rs2Hit);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: redirect, multi-cycle EX, load-use and
// debug halt arbitration. Debug halt/step is built only with HAZARD_CTRL_DEBUG_EN.
module hazard_ctrl #(
   parameter int N      = defines::N,
   parameter int MC_LAT = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [defines::REG_AW-1:0] id_rs1,
   input  logic [defines::REG_AW-1:0] id_rs2,
   input  logic                       id_use_rs1,
   input  logic                       id_use_rs2,
   input  logic [defines::REG_AW-1:0] ex_rd,
   input  logic                       ex_mem_read,
   input  logic                       ex_mc_start,
   input  logic                       ex_br_taken,
   input  logic [N-1:0]               ex_br_offset,
`ifdef HAZARD_CTRL_DEBUG_EN
   input  logic                       dbg_halt_req,
   input  logic                       dbg_step,
`endif
   output logic                       pc_freeze,
   output logic                       br_taken,
   output logic [N-1:0]               br_offset,
   output logic                       ifid_freeze,
   output logic                       ifid_flush,
   output logic                       idex_bubble,
   output logic                       ex_hold,
   output logic                       mc_busy,
   output logic                       dbg_halted
);
   import defines::*;

   // The start cycle is the first stall cycle, so MC itself lasts MC_LAT-2 cycles.
   localparam logic [MC_CNT_W-1:0] MC_LOAD   = MC_CNT_W'(MC_LAT - 2);
   localparam bit                  MC_STALLS = (MC_LAT > 2);

   hz_state_t            state;
   logic [MC_CNT_W-1:0]  mcCnt;
   logic                 mcBusyQ;
   logic                 loadUse;
   logic                 runLike;
   logic                 startMc;
`ifdef HAZARD_CTRL_DEBUG_EN
   logic                 haltedQ;
   logic                 enterHalt;
`endif

   loaduse_detect uLoadUse (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .hazard      (loadUse)
   );

`ifdef HAZARD_CTRL_DEBUG_EN
   assign runLike = (state == RUN) || (state == STEP);
`else
   assign runLike = (state == RUN);
`endif

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      pc_freeze   = 1'b0;
      br_taken    = 1'b0;
      br_offset   = '0;
      ifid_freeze = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      ex_hold     = 1'b0;
      startMc     = 1'b0;
`ifdef HAZARD_CTRL_DEBUG_EN
      enterHalt   = 1'b0;
`endif
      if (!rst) begin
         if (runLike) begin
            // Only the highest-priority event is acted on this cycle.
            if (ex_br_taken) begin
               br_taken    = 1'b1;
               br_offset   = ex_br_offset;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (ex_mc_start) begin
               pc_freeze   = 1'b1;
               ifid_freeze = 1'b1;
               idex_bubble = 1'b1;
               ex_hold     = 1'b1;
               startMc     = 1'b1;
            end else if (loadUse) begin
               pc_freeze   = 1'b1;
               ifid_freeze = 1'b1;
               idex_bubble = 1'b1;
`ifdef HAZARD_CTRL_DEBUG_EN
            end else if (dbg_halt_req && (state == RUN)) begin
               pc_freeze   = 1'b1;
               ifid_freeze = 1'b1;
               idex_bubble = 1'b1;
               enterHalt   = 1'b1;
`endif
            end
         end else if (state == MC) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            idex_bubble = 1'b1;
            ex_hold     = 1'b1;
`ifdef HAZARD_CTRL_DEBUG_EN
         end else if (state == HALT) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            idex_bubble = 1'b1;
`endif
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         mcCnt   <= '0;
         mcBusyQ <= 1'b0;
`ifdef HAZARD_CTRL_DEBUG_EN
         haltedQ <= 1'b0;
`endif
      end else begin
         case (state)
            RUN: begin
               if (startMc) begin
                  mcCnt <= MC_LOAD;
                  if (MC_STALLS) begin
                     state   <= MC;
                     mcBusyQ <= 1'b1;
                  end
`ifdef HAZARD_CTRL_DEBUG_EN
               end else if (enterHalt) begin
                  state   <= HALT;
                  haltedQ <= 1'b1;
`endif
               end
            end
            MC: begin
               mcCnt <= mcCnt - 1'b1;
               if (mcCnt == MC_CNT_W'(1)) begin
                  state   <= RUN;
                  mcBusyQ <= 1'b0;
               end
            end
`ifdef HAZARD_CTRL_DEBUG_EN
            HALT: begin
               if (!dbg_halt_req) begin
                  state   <= RUN;
                  haltedQ <= 1'b0;
               end else if (dbg_step) begin
                  state   <= STEP;
                  haltedQ <= 1'b0;
               end
            end
            STEP: begin
               // A multi-cycle op started while stepping finishes in MC, then RUN re-halts.
               if (startMc) begin
                  mcCnt <= MC_LOAD;
               end
               if (startMc && MC_STALLS) begin
                  state   <= MC;
                  mcBusyQ <= 1'b1;
               end else begin
                  state   <= HALT;
                  haltedQ <= 1'b1;
               end
            end
`endif
            default: begin
               state   <= RUN;
               mcCnt   <= '0;
               mcBusyQ <= 1'b0;
            end
         endcase
      end
   end

   assign mc_busy = mcBusyQ && !rst;
`ifdef HAZARD_CTRL_DEBUG_EN
   assign dbg_halted = haltedQ && !rst;
`else
   assign dbg_halted = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: MC_LAT=4 and MC_LAT=2 instances share stimulus;
// table vectors for single-cycle rules, hand sequences for multi-cycle cases.
module tb_hazard_ctrl;
   // Control bundle order: {pc_freeze, br_taken, ifid_freeze, ifid_flush,
   //                        idex_bubble, ex_hold, mc_busy, dbg_halted}
   localparam logic [7:0] C_NONE = 8'b0000_0000;
   localparam logic [7:0] C_LU   = 8'b1010_1000;
   localparam logic [7:0] C_BR   = 8'b0101_1000;
   localparam logic [7:0] C_MCS  = 8'b1010_1100;
   localparam logic [7:0] C_MCB  = 8'b1010_1110;
   localparam logic [7:0] C_HLT  = 8'b1010_1001;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  idRs1, idRs2, exRd;
   logic        idUseRs1, idUseRs2, exMemRead, exMcStart, exBrTaken;
   logic [31:0] exBrOffset;
   logic        dbgHaltReq, dbgStep;

   logic        pf4, bt4, iff4, ifl4, ib4, eh4, mb4, dh4;
   logic [31:0] bo4;
   logic        pf2, bt2, iff2, ifl2, ib2, eh2, mb2, dh2;
   logic [31:0] bo2;
   logic [7:0]  ctl4, ctl2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign ctl4 = {pf4, bt4, iff4, ifl4, ib4, eh4, mb4, dh4};
   assign ctl2 = {pf2, bt2, iff2, ifl2, ib2, eh2, mb2, dh2};

   hazard_ctrl #(.N(32), .MC_LAT(4)) dut4 (
      .clk(clk), .rst(rst),
      .id_rs1(idRs1), .id_rs2(idRs2), .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
      .ex_rd(exRd), .ex_mem_read(exMemRead), .ex_mc_start(exMcStart),
      .ex_br_taken(exBrTaken), .ex_br_offset(exBrOffset),
`ifdef HAZARD_CTRL_DEBUG_EN
      .dbg_halt_req(dbgHaltReq), .dbg_step(dbgStep),
`endif
      .pc_freeze(pf4), .br_taken(bt4), .br_offset(bo4), .ifid_freeze(iff4),
      .ifid_flush(ifl4), .idex_bubble(ib4), .ex_hold(eh4), .mc_busy(mb4),
      .dbg_halted(dh4)
   );

   hazard_ctrl #(.N(32), .MC_LAT(2)) dut2 (
      .clk(clk), .rst(rst),
      .id_rs1(idRs1), .id_rs2(idRs2), .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
      .ex_rd(exRd), .ex_mem_read(exMemRead), .ex_mc_start(exMcStart),
      .ex_br_taken(exBrTaken), .ex_br_offset(exBrOffset),
`ifdef HAZARD_CTRL_DEBUG_EN
      .dbg_halt_req(dbgHaltReq), .dbg_step(dbgStep),
`endif
      .pc_freeze(pf2), .br_taken(bt2), .br_offset(bo2), .ifid_freeze(iff2),
      .ifid_flush(ifl2), .idex_bubble(ib2), .ex_hold(eh2), .mc_busy(mb2),
      .dbg_halted(dh2)
   );

   typedef struct {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        use1;
      logic        use2;
      logic [4:0]  rd;
      logic        memRead;
      logic        brTaken;
      logic [31:0] brOff;
      logic [7:0]  expCtl;
      logic [31:0] expOff;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic use1, input logic use2, input logic [4:0] rd,
                               input logic memRead, input logic brTaken,
                               input logic [31:0] brOff, input logic [7:0] expCtl,
                               input logic [31:0] expOff);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2; v.rd = rd;
      v.memRead = memRead; v.brTaken = brTaken; v.brOff = brOff;
      v.expCtl = expCtl; v.expOff = expOff;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clearIn();
      idRs1 = '0; idRs2 = '0; idUseRs1 = 0; idUseRs2 = 0; exRd = '0;
      exMemRead = 0; exMcStart = 0; exBrTaken = 0; exBrOffset = '0;
      dbgHaltReq = 0; dbgStep = 0;
   endtask

   task automatic setLoadUseHit();
      exMemRead = 1; exRd = 5'd5; idRs2 = 5'd5; idUseRs2 = 1;
   endtask

   // Inputs are driven just after a rising edge; outputs are sampled mid-cycle.
   task automatic settle();
      #4;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clearIn();
      nextCycle();

      // Reset: outputs forced low even with active hazard inputs.
      exBrTaken = 1; exBrOffset = 32'h55; exMcStart = 1; setLoadUseHit();
      settle();
      check("rst_ctl4", 32'(ctl4), 32'(C_NONE));
      check("rst_off4", bo4, 32'h0);
      check("rst_ctl2", 32'(ctl2), 32'(C_NONE));
      nextCycle();
      rst = 1'b0;
      clearIn();

      vecs[0]  = mk(5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 32'h0,        C_NONE, 32'h0);
      vecs[1]  = mk(5'd0,  5'd5,  0, 1, 5'd5,  1, 0, 32'h0,        C_LU,   32'h0);
      vecs[2]  = mk(5'd0,  5'd0,  0, 1, 5'd0,  1, 0, 32'h0,        C_NONE, 32'h0);
      vecs[3]  = mk(5'd7,  5'd0,  1, 0, 5'd7,  1, 0, 32'h0,        C_LU,   32'h0);
      vecs[4]  = mk(5'd7,  5'd0,  0, 0, 5'd7,  1, 0, 32'h0,        C_NONE, 32'h0);
      vecs[5]  = mk(5'd7,  5'd7,  1, 1, 5'd7,  0, 0, 32'h0,        C_NONE, 32'h0);
      vecs[6]  = mk(5'd3,  5'd9,  1, 0, 5'd9,  1, 0, 32'h0,        C_NONE, 32'h0);
      vecs[7]  = mk(5'd0,  5'd5,  0, 1, 5'd5,  1, 1, 32'hFFFFFFFE, C_BR,   32'hFFFFFFFE);
      vecs[8]  = mk(5'd0,  5'd0,  0, 0, 5'd0,  0, 1, 32'h10,       C_BR,   32'h10);
      vecs[9]  = mk(5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 32'h1234,     C_NONE, 32'h0);
      vecs[10] = mk(5'd31, 5'd2,  1, 1, 5'd31, 1, 0, 32'h0,        C_LU,   32'h0);

      for (int i = 0; i < 11; i++) begin
         idRs1 = vecs[i].rs1; idRs2 = vecs[i].rs2;
         idUseRs1 = vecs[i].use1; idUseRs2 = vecs[i].use2;
         exRd = vecs[i].rd; exMemRead = vecs[i].memRead;
         exBrTaken = vecs[i].brTaken; exBrOffset = vecs[i].brOff;
         settle();
         check($sformatf("vec%0d_ctl4", i), 32'(ctl4), 32'(vecs[i].expCtl));
         check($sformatf("vec%0d_off4", i), bo4, vecs[i].expOff);
         check($sformatf("vec%0d_ctl2", i), 32'(ctl2), 32'(vecs[i].expCtl));
         nextCycle();
      end
      clearIn();

      // Multi-cycle op (beats a concurrent load-use), MC_LAT=4 vs MC_LAT=2.
      exMcStart = 1; setLoadUseHit();
      settle();
      check("mc_c0_ctl4", 32'(ctl4), 32'(C_MCS));
      check("mc_c0_ctl2", 32'(ctl2), 32'(C_MCS));
      nextCycle();
      clearIn();
      exBrTaken = 1; exBrOffset = 32'h8;
      settle();
      check("mc_c1_ctl4", 32'(ctl4), 32'(C_MCB));
      check("mc_c1_off4", bo4, 32'h0);
      check("mc_c1_ctl2", 32'(ctl2), 32'(C_BR));
      check("mc_c1_off2", bo2, 32'h8);
      nextCycle();
      clearIn();
      setLoadUseHit();
      settle();
      check("mc_c2_ctl4", 32'(ctl4), 32'(C_MCB));
      check("mc_c2_ctl2", 32'(ctl2), 32'(C_LU));
      nextCycle();
      clearIn();
      settle();
      check("mc_c3_ctl4", 32'(ctl4), 32'(C_NONE));
      check("mc_c3_ctl2", 32'(ctl2), 32'(C_NONE));
      nextCycle();

      // Redirect wins over a same-cycle multi-cycle start; no MC follows.
      exBrTaken = 1; exBrOffset = 32'h40; exMcStart = 1;
      settle();
      check("brmc_ctl4", 32'(ctl4), 32'(C_BR));
      check("brmc_off4", bo4, 32'h40);
      nextCycle();
      clearIn();
      settle();
      check("brmc_next_ctl4", 32'(ctl4), 32'(C_NONE));
      nextCycle();

      // Reset while in MC aborts the stall.
      exMcStart = 1;
      settle();
      check("mcrst_c0_ctl4", 32'(ctl4), 32'(C_MCS));
      nextCycle();
      clearIn();
      rst = 1'b1;
      settle();
      check("mcrst_c1_ctl4", 32'(ctl4), 32'(C_NONE));
      nextCycle();
      rst = 1'b0;
      settle();
      check("mcrst_c2_ctl4", 32'(ctl4), 32'(C_NONE));
      nextCycle();
      settle();
      check("mcrst_c3_ctl4", 32'(ctl4), 32'(C_NONE));
      nextCycle();

`ifdef HAZARD_CTRL_DEBUG_EN
      // Halt, single step, release.
      dbgHaltReq = 1;
      settle();
      check("dbg_enter_ctl4", 32'(ctl4), 32'(C_LU));
      nextCycle();
      settle();
      check("dbg_halt_ctl4", 32'(ctl4), 32'(C_HLT));
      nextCycle();
      dbgStep = 1;
      settle();
      check("dbg_stepreq_ctl4", 32'(ctl4), 32'(C_HLT));
      nextCycle();
      dbgStep = 0;
      settle();
      check("dbg_step_ctl4", 32'(ctl4), 32'(C_NONE));
      nextCycle();
      settle();
      check("dbg_rehalt_ctl4", 32'(ctl4), 32'(C_HLT));
      nextCycle();
      dbgHaltReq = 0;
      settle();
      check("dbg_release_ctl4", 32'(ctl4), 32'(C_HLT));
      nextCycle();
      settle();
      check("dbg_run_ctl4", 32'(ctl4), 32'(C_NONE));
      nextCycle();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
